// File: rtl/bcd_hex_updown_counter_7seg.sv
// N-digit up/down counter (hex or BCD digits, wrap or saturate) with a
// registered, one-hot multiplexed 7-segment scan of the current count.
`timescale 1ns/1ps
module bcd_hex_updown_counter_7seg #(
    parameter int NDIGITS   = 2,
    parameter int RADIX_BCD = 0,
    parameter int SCAN_DIV  = 4
) (
    input  logic                 clk_2,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 up_dn,
    input  logic                 sat,
    input  logic                 load,
    input  logic [4*NDIGITS-1:0] load_val,
    output logic [4*NDIGITS-1:0] count,
    output logic                 tc,
    output logic                 ovf,
    output logic [NDIGITS-1:0]   digit_sel,
    output logic [7:0]           seg
);
    localparam int W  = 4 * NDIGITS;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [3:0]   DMAX = (RADIX_BCD != 0) ? 4'd9 : 4'd15;
    localparam logic [W-1:0] MAXV = {NDIGITS{DMAX}};

    logic [W-1:0]       count_q, count_d;
    logic               tc_q, tc_d;
    logic               ovf_q, ovf_d;
    logic [SW-1:0]      scan_cnt_q, scan_cnt_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [NDIGITS-1:0] digit_sel_q, digit_sel_d;
    logic [7:0]         seg_q, seg_d;

    logic [NDIGITS-1:0] dig_max, dig_zero;
    logic [W-1:0]       load_fix, inc_val, dec_val;
    logic               carry, borrow;
    logic               at_max, at_zero;
    logic [3:0]         shown_digit;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;  4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;  default: glyph = 7'h71;
        endcase
    endfunction

    // Per-digit bound detection and load clamping (digits above 9 become 9 in BCD)
    generate
        for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_digit
            logic [3:0] cur_dig;
            logic [3:0] ld_dig;
            assign cur_dig  = count_q[4*gi +: 4];
            assign ld_dig   = load_val[4*gi +: 4];
            assign dig_max[gi]  = (cur_dig == DMAX);
            assign dig_zero[gi] = (cur_dig == 4'd0);
            assign load_fix[4*gi +: 4] = ((RADIX_BCD != 0) && (ld_dig > 4'd9)) ? 4'd9 : ld_dig;
        end
    endgenerate

    assign at_max  = &dig_max;
    assign at_zero = &dig_zero;

    // Ripple carry/borrow digit by digit so hex and BCD share one structure
    always_comb begin
        inc_val = count_q;
        dec_val = count_q;
        carry   = 1'b1;
        borrow  = 1'b1;
        for (int i = 0; i < NDIGITS; i++) begin
            if (carry)
                inc_val[4*i +: 4] = dig_max[i] ? 4'd0 : count_q[4*i +: 4] + 4'd1;
            if (borrow)
                dec_val[4*i +: 4] = dig_zero[i] ? DMAX : count_q[4*i +: 4] - 4'd1;
            carry  = carry & dig_max[i];
            borrow = borrow & dig_zero[i];
        end
    end

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q;
        if (load) begin
            count_d = load_fix;
            ovf_d   = 1'b0;
        end else if (en) begin
            if (!up_dn) begin
                if (at_max) begin
                    tc_d    = 1'b1;
                    ovf_d   = 1'b1;
                    count_d = sat ? count_q : '0;
                end else begin
                    count_d = inc_val;
                end
            end else begin
                if (at_zero) begin
                    tc_d    = 1'b1;
                    ovf_d   = 1'b1;
                    count_d = sat ? count_q : MAXV;
                end else begin
                    count_d = dec_val;
                end
            end
        end
    end

    // Select and glyph use the next index so digit_sel and seg switch together
    always_comb begin
        scan_cnt_d = scan_cnt_q + SW'(1);
        idx_d      = idx_q;
        if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            idx_d      = (idx_q == IW'(NDIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
        shown_digit = count_q[3:0];
        for (int i = 0; i < NDIGITS; i++) begin
            if (idx_d == IW'(i))
                shown_digit = count_q[4*i +: 4];
        end
        digit_sel_d = NDIGITS'(1) << idx_d;
        seg_d       = {ovf_q && (idx_d == IW'(NDIGITS - 1)), glyph(shown_digit)};
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            count_q     <= '0;
            tc_q        <= 1'b0;
            ovf_q       <= 1'b0;
            scan_cnt_q  <= '0;
            idx_q       <= '0;
            digit_sel_q <= NDIGITS'(1);
            seg_q       <= 8'h3F;
        end else begin
            count_q     <= count_d;
            tc_q        <= tc_d;
            ovf_q       <= ovf_d;
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
            digit_sel_q <= digit_sel_d;
            seg_q       <= seg_d;
        end
    end

    assign count     = count_q;
    assign tc        = tc_q;
    assign ovf       = ovf_q;
    assign digit_sel = digit_sel_q;
    assign seg       = seg_q;

endmodule

// File: tb/tb_bcd_hex_updown_counter_7seg.sv
// Directed bench for the counter/7-seg block: a hex and a BCD instance share
// stimulus; a behavioural model queues expected outputs each cycle.
`timescale 1ns/1ps
module tb_bcd_hex_updown_counter_7seg;

    logic       clk_2 = 1'b0;
    logic       reset;
    logic       en, up_dn, sat, load;
    logic [7:0] load_val;

    logic [7:0] count_h, count_b, seg_h, seg_b;
    logic       tc_h, tc_b, ovf_h, ovf_b;
    logic [1:0] sel_h, sel_b;

    always #5 clk_2 = ~clk_2;

    bcd_hex_updown_counter_7seg #(.NDIGITS(2), .RADIX_BCD(0), .SCAN_DIV(4)) u_hex (
        .clk_2(clk_2), .reset(reset), .en(en), .up_dn(up_dn), .sat(sat),
        .load(load), .load_val(load_val), .count(count_h), .tc(tc_h),
        .ovf(ovf_h), .digit_sel(sel_h), .seg(seg_h));

    bcd_hex_updown_counter_7seg #(.NDIGITS(2), .RADIX_BCD(1), .SCAN_DIV(4)) u_bcd (
        .clk_2(clk_2), .reset(reset), .en(en), .up_dn(up_dn), .sat(sat),
        .load(load), .load_val(load_val), .count(count_b), .tc(tc_b),
        .ovf(ovf_b), .digit_sel(sel_b), .seg(seg_b));

    typedef struct packed {
        logic [7:0] count;
        logic       tc;
        logic       ovf;
        logic [1:0] sel;
        logic [7:0] seg;
    } exp_t;

    exp_t q_hex[$];
    exp_t q_bcd[$];

    logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model: plain integer value per instance (decimal for BCD), plus scan position
    int m_val [2];
    bit m_tc  [2];
    bit m_ovf [2];
    int s_cnt, s_idx;

    int checks = 0;
    int errors = 0;
    int step_no = 0;
    int tcs;

    function automatic logic [7:0] pack(input int r, input int v);
        if (r == 0) return 8'(v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s step %0d observed=%0h expected=%0h", tag, step_no, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 2; r++) begin
            m_val[r] = 0;
            m_tc[r]  = 1'b0;
            m_ovf[r] = 1'b0;
        end
        s_cnt = 0;
        s_idx = 0;
        q_hex.delete();
        q_bcd.delete();
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_count_h"}, 32'(count_h), 32'h00);
        check({tag, "_tc_h"},    32'(tc_h),    32'h0);
        check({tag, "_ovf_h"},   32'(ovf_h),   32'h0);
        check({tag, "_sel_h"},   32'(sel_h),   32'h1);
        check({tag, "_seg_h"},   32'(seg_h),   32'h3F);
        check({tag, "_count_b"}, 32'(count_b), 32'h00);
        check({tag, "_tc_b"},    32'(tc_b),    32'h0);
        check({tag, "_ovf_b"},   32'(ovf_b),   32'h0);
        check({tag, "_sel_b"},   32'(sel_b),   32'h1);
        check({tag, "_seg_b"},   32'(seg_b),   32'h3F);
    endtask

    task automatic cycle(input logic ld, input logic [7:0] lv, input logic e,
                         input logic ud, input logic s);
        exp_t       ex;
        logic [7:0] prev, sh;
        int         mx, d1, d0;
        load = ld; load_val = lv; en = e; up_dn = ud; sat = s;
        step_no++;
        if (s_cnt == 3) begin
            s_cnt = 0;
            s_idx = (s_idx + 1) % 2;
        end else begin
            s_cnt++;
        end
        for (int r = 0; r < 2; r++) begin
            mx   = (r == 0) ? 255 : 99;
            prev = pack(r, m_val[r]);
            sh   = prev >> (4 * s_idx);
            ex.seg = {m_ovf[r] && (s_idx == 1), glyph_tab[sh[3:0]]};
            ex.sel = (s_idx == 0) ? 2'b01 : 2'b10;
            m_tc[r] = 1'b0;
            if (ld) begin
                if (r == 0) begin
                    m_val[r] = int'(lv);
                end else begin
                    d1 = (int'(lv[7:4]) > 9) ? 9 : int'(lv[7:4]);
                    d0 = (int'(lv[3:0]) > 9) ? 9 : int'(lv[3:0]);
                    m_val[r] = d1 * 10 + d0;
                end
                m_ovf[r] = 1'b0;
            end else if (e) begin
                if (!ud) begin
                    if (m_val[r] == mx) begin
                        m_tc[r] = 1'b1; m_ovf[r] = 1'b1;
                        if (!s) m_val[r] = 0;
                    end else m_val[r] = m_val[r] + 1;
                end else begin
                    if (m_val[r] == 0) begin
                        m_tc[r] = 1'b1; m_ovf[r] = 1'b1;
                        if (!s) m_val[r] = mx;
                    end else m_val[r] = m_val[r] - 1;
                end
            end
            ex.count = pack(r, m_val[r]);
            ex.tc    = m_tc[r];
            ex.ovf   = m_ovf[r];
            if (r == 0) q_hex.push_back(ex);
            else        q_bcd.push_back(ex);
        end
        @(posedge clk_2);
        #1;
        ex = q_hex.pop_front();
        check("hex_count", 32'(count_h), 32'(ex.count));
        check("hex_tc",    32'(tc_h),    32'(ex.tc));
        check("hex_ovf",   32'(ovf_h),   32'(ex.ovf));
        check("hex_sel",   32'(sel_h),   32'(ex.sel));
        check("hex_seg",   32'(seg_h),   32'(ex.seg));
        ex = q_bcd.pop_front();
        check("bcd_count", 32'(count_b), 32'(ex.count));
        check("bcd_tc",    32'(tc_b),    32'(ex.tc));
        check("bcd_ovf",   32'(ovf_b),   32'(ex.ovf));
        check("bcd_sel",   32'(sel_b),   32'(ex.sel));
        check("bcd_seg",   32'(seg_b),   32'(ex.seg));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; en = 1'b0; up_dn = 1'b0; sat = 1'b0; load = 1'b0; load_val = 8'h00;
        model_reset();
        #1;
        check_reset("por");
        @(posedge clk_2);
        #1;
        reset = 1'b0;

        // Hex wrap going up
        cycle(1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
        tcs = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            tcs += int'(tc_h);
        end
        check("hex_wrap_end", 32'(count_h), 32'h01);
        check("hex_wrap_tc_pulses", 32'(tcs), 32'd1);
        check("hex_wrap_ovf", 32'(ovf_h), 32'h1);

        // BCD wrap up, BCD borrow down, load clamp
        cycle(1'b1, 8'h98, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("bcd_wrap_end", 32'(count_b), 32'h01);
        cycle(1'b1, 8'h10, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        check("bcd_borrow", 32'(count_b), 32'h09);
        cycle(1'b1, 8'hAF, 1'b0, 1'b0, 1'b0);
        check("bcd_clamp", 32'(count_b), 32'h99);

        // Saturate at zero going down
        cycle(1'b1, 8'h01, 1'b0, 1'b1, 1'b1);
        tcs = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
            tcs += int'(tc_h);
        end
        check("sat_hold", 32'(count_h), 32'h00);
        check("sat_tc_pulses", 32'(tcs), 32'd2);
        check("sat_ovf", 32'(ovf_h), 32'h1);

        // Load beats enable, then hold
        cycle(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
        check("prio_tc", 32'(tc_h), 32'h0);
        check("prio_ovf", 32'(ovf_h), 32'h0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("prio_hold", 32'(count_h), 32'h5A);

        // Build count 3C with ovf set, then watch the scan
        cycle(1'b1, 8'h00, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 60; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            check("scan_seg_h", 32'(seg_h), (s_idx == 0) ? 32'h39 : 32'hCF);
        end

        // Asynchronous reset mid-count
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        check_reset("async");
        @(posedge clk_2);
        #1;
        check_reset("held");
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
